// File: rtl/gba_ppu_pkg.sv
// Shared PPU types: fetch FSM states, the text-map entry layout and VRAM block geometry.
package gba_ppu_pkg;

   localparam int SCREEN_W       = 240;
   localparam int MAP_W          = 32;
   localparam int CHAR_BLK_WORDS = 4096;
   localparam int SCR_BLK_WORDS  = 512;

   typedef enum logic [2:0] {
      IDLE,
      MAP,
      ROW0,
      ROW1,
      EMIT,
      DONE
   } fetch_state_t;

   // Field order matches the 16-bit halfword stored in the screen block.
   typedef struct packed {
      logic [3:0] pal;
      logic       vflip;
      logic       hflip;
      logic [9:0] tile;
   } map_entry_t;

endpackage

// File: rtl/bg_row_unpack.sv
// Picks one pixel out of a fetched tile row and forms its palette index and transparency flag.
module bg_row_unpack
   import gba_ppu_pkg::*;
(
   input  logic [63:0] row,
   input  logic        bpp8,
   input  logic        hflip,
   input  logic [3:0]  pal,
   input  logic [2:0]  pix,
   output logic [7:0]  pix_index,
   output logic        pix_transp
);

   logic [2:0] sel;
   logic [3:0] nib;
   logic [7:0] byt;

   // Pixel 0 sits in the least significant nibble/byte; hflip mirrors the index to 7-p.
   always_comb begin
      sel = hflip ? ~pix : pix;
      nib = row[{sel, 2'b00} +: 4];
      byt = row[{sel, 3'b000} +: 8];
      if (bpp8) begin
         pix_index  = byt;
         pix_transp = (byt == 8'h00);
      end else begin
         pix_index  = {pal, nib};
         pix_transp = (nib == 4'h0);
      end
   end

endmodule

// File: rtl/bg_text_line_fetch.sv
// Text-mode background line fetcher: walks map entries and tile rows in VRAM for one scanline
// and streams palette indices to the line compositor over a valid/ready handshake.
module bg_text_line_fetch #(
   parameter int RD_LAT   = 1,
   parameter int SCREEN_W = 240
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  line,
   input  logic [7:0]  hofs,
   input  logic [7:0]  vofs,
   input  logic [4:0]  sbb,
   input  logic [1:0]  cbb,
   input  logic        bpp8,
   output logic [13:0] vram_addr,
   output logic        vram_rd,
   input  logic [31:0] vram_dout,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [7:0]  pix_x,
   output logic [7:0]  pix_index,
   output logic        pix_transp,
   output logic        busy,
   output logic        done
);

   import gba_ppu_pkg::*;

   localparam logic [1:0] LAT_LAST = 2'(RD_LAT);
   localparam logic [7:0] X_LAST   = 8'(SCREEN_W - 1);

   fetch_state_t state, state_nxt;

   logic [4:0]  r_row;
   logic [2:0]  r_fy;
   logic [4:0]  r_col0;
   logic [4:0]  r_sbb;
   logic [1:0]  r_cbb;
   logic        r_bpp8;
   logic [1:0]  lat_cnt;
   logic [4:0]  tile_cnt;
   logic [2:0]  px;
   logic [7:0]  x;
   map_entry_t  entry;
   logic [63:0] row_data;

   logic [7:0]  y_start;
   logic [4:0]  col;
   logic        lat_last;
   logic        last_x;
   logic [2:0]  ry;
   logic [13:0] map_base;
   logic [13:0] char_base;
   logic [13:0] map_addr;
   logic [13:0] row_addr4;
   logic [13:0] row_addr8;
   logic [15:0] map_half;
   logic [7:0]  u_index;
   logic        u_transp;

   // Map is 32 entries wide and wraps; two 16-bit entries share each VRAM word.
   assign y_start   = line + vofs;
   assign col       = r_col0 + tile_cnt;
   assign lat_last  = (lat_cnt == LAT_LAST);
   assign last_x    = (x == X_LAST);
   assign ry        = entry.vflip ? ~r_fy : r_fy;
   assign map_base  = 14'(r_sbb * SCR_BLK_WORDS);
   assign char_base = 14'(r_cbb * CHAR_BLK_WORDS);
   assign map_addr  = map_base + 14'({r_row, col[4:1]});
   assign row_addr4 = char_base + 14'({entry.tile, ry});
   assign row_addr8 = char_base + {entry.tile, ry, 1'b0};
   assign map_half  = col[0] ? vram_dout[31:16] : vram_dout[15:0];

   bg_row_unpack u_unpack (
      .row        (row_data),
      .bpp8       (r_bpp8),
      .hflip      (entry.hflip),
      .pal        (entry.pal),
      .pix        (px),
      .pix_index  (u_index),
      .pix_transp (u_transp)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and all outputs; pixel outputs read zero outside EMIT so reset and idle look clean.
   always_comb begin
      state_nxt  = state;
      vram_addr  = '0;
      vram_rd    = 1'b0;
      pix_valid  = 1'b0;
      pix_x      = '0;
      pix_index  = '0;
      pix_transp = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = MAP;
         end
         MAP: begin
            vram_rd   = 1'b1;
            vram_addr = map_addr;
            if (lat_last) state_nxt = ROW0;
         end
         ROW0: begin
            vram_rd   = 1'b1;
            vram_addr = r_bpp8 ? row_addr8 : row_addr4;
            if (lat_last) state_nxt = r_bpp8 ? ROW1 : EMIT;
         end
         ROW1: begin
            vram_rd   = 1'b1;
            vram_addr = row_addr8 + 14'd1;
            if (lat_last) state_nxt = EMIT;
         end
         EMIT: begin
            pix_valid  = 1'b1;
            pix_x      = x;
            pix_index  = u_index;
            pix_transp = u_transp;
            if (pix_ready) begin
               if (last_x)           state_nxt = DONE;
               else if (px == 3'd7)  state_nxt = MAP;
            end
         end
         DONE: begin
            busy      = 1'b0;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // Line parameters are frozen at start; tile 0 begins at the fine-scroll pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row    <= '0;
         r_fy     <= '0;
         r_col0   <= '0;
         r_sbb    <= '0;
         r_cbb    <= '0;
         r_bpp8   <= 1'b0;
         lat_cnt  <= '0;
         tile_cnt <= '0;
         px       <= '0;
         x        <= '0;
         entry    <= '0;
         row_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  r_row    <= y_start[7:3];
                  r_fy     <= y_start[2:0];
                  r_col0   <= hofs[7:3];
                  px       <= hofs[2:0];
                  r_sbb    <= sbb;
                  r_cbb    <= cbb;
                  r_bpp8   <= bpp8;
                  lat_cnt  <= '0;
                  tile_cnt <= '0;
                  x        <= '0;
               end
            end
            MAP, ROW0, ROW1: begin
               if (lat_last) begin
                  lat_cnt <= '0;
                  if (state == MAP)       entry <= map_entry_t'(map_half);
                  else if (state == ROW0) row_data[31:0] <= vram_dout;
                  else                    row_data[63:32] <= vram_dout;
               end else begin
                  lat_cnt <= lat_cnt + 2'd1;
               end
            end
            EMIT: begin
               if (pix_ready) begin
                  x  <= x + 8'd1;
                  px <= px + 3'd1;
                  if (px == 3'd7) tile_cnt <= tile_cnt + 5'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bg_text_line_fetch.sv
// Directed bench: two fetchers (read latency 0 and 1) share one VRAM image; every scenario runs on each.
module tb_bg_text_line_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  start_v;
   logic [7:0]  line, hofs, vofs;
   logic [4:0]  sbb;
   logic [1:0]  cbb;
   logic        bpp8;
   logic        pix_ready;

   logic [31:0] mem [0:16383];

   logic [13:0] addr0, addr1;
   logic        rd0, rd1;
   logic [31:0] dout0, dout1;
   logic        v0, v1, t0, t1, b0, b1, d0, d1;
   logic [7:0]  x0o, x1o, i0, i1;

   int          sel;
   logic [13:0] s_addr;
   logic        s_rd, s_valid, s_transp, s_busy, s_done;
   logic [7:0]  s_x, s_index;

   int          n_asserts = 0;
   int          n_fail = 0;

   logic        log_clr = 1'b0;
   int          pix_cnt, done_cnt, rd_log_cnt, emit_rd_cnt, busy_cycles, x_err;
   logic [7:0]  pix_idx_log [0:255];
   logic        pix_tr_log  [0:255];
   logic [13:0] rd_log      [0:63];
   logic        prev_rd;
   logic [13:0] prev_addr;

   always #5 clk = ~clk;

   assign dout0 = mem[addr0];
   always @(posedge clk) dout1 <= mem[addr1];

   bg_text_line_fetch #(.RD_LAT(0), .SCREEN_W(240)) dut0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .line(line), .hofs(hofs), .vofs(vofs),
      .sbb(sbb), .cbb(cbb), .bpp8(bpp8), .vram_addr(addr0), .vram_rd(rd0), .vram_dout(dout0),
      .pix_valid(v0), .pix_ready(pix_ready), .pix_x(x0o), .pix_index(i0), .pix_transp(t0),
      .busy(b0), .done(d0)
   );

   bg_text_line_fetch #(.RD_LAT(1), .SCREEN_W(240)) dut1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .line(line), .hofs(hofs), .vofs(vofs),
      .sbb(sbb), .cbb(cbb), .bpp8(bpp8), .vram_addr(addr1), .vram_rd(rd1), .vram_dout(dout1),
      .pix_valid(v1), .pix_ready(pix_ready), .pix_x(x1o), .pix_index(i1), .pix_transp(t1),
      .busy(b1), .done(d1)
   );

   always_comb begin
      if (sel == 1) begin
         s_addr = addr1; s_rd = rd1; s_valid = v1; s_x = x1o; s_index = i1;
         s_transp = t1; s_busy = b1; s_done = d1;
      end else begin
         s_addr = addr0; s_rd = rd0; s_valid = v0; s_x = x0o; s_index = i0;
         s_transp = t0; s_busy = b0; s_done = d0;
      end
   end

   // Observes the selected fetcher mid-cycle: accepted pixels, distinct read addresses, done pulses.
   always @(negedge clk) begin
      if (log_clr) begin
         pix_cnt <= 0; done_cnt <= 0; rd_log_cnt <= 0; emit_rd_cnt <= 0;
         busy_cycles <= 0; x_err <= 0; prev_rd <= 1'b0; prev_addr <= '0;
      end else begin
         if (s_valid && pix_ready) begin
            if (s_x != pix_cnt[7:0]) x_err <= x_err + 1;
            if (pix_cnt < 256) begin
               pix_idx_log[pix_cnt] <= s_index;
               pix_tr_log[pix_cnt]  <= s_transp;
            end
            pix_cnt <= pix_cnt + 1;
         end
         if (s_rd && (!prev_rd || s_addr != prev_addr)) begin
            if (rd_log_cnt < 64) rd_log[rd_log_cnt] <= s_addr;
            rd_log_cnt <= rd_log_cnt + 1;
         end
         if (s_valid && s_rd) emit_rd_cnt <= emit_rd_cnt + 1;
         if (s_busy) busy_cycles <= busy_cycles + 1;
         if (s_done) done_cnt <= done_cnt + 1;
         prev_rd   <= s_rd;
         prev_addr <= s_addr;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_asserts++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s (RD_LAT=%0d): observed %0h expected %0h", tag, sel, observed, expected);
      end
   endtask

   task automatic clearMem();
      for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
   endtask

   task automatic clearLog();
      @(posedge clk); #1 log_clr = 1'b1;
      @(negedge clk); #1 log_clr = 1'b0;
   endtask

   // Pulses start for the selected fetcher, then scrambles the inputs to prove they were latched.
   task automatic applyStimulus(input logic [7:0] ln, input logic [7:0] ho, input logic [7:0] vo,
                                input logic [4:0] sb, input logic [1:0] cb, input logic b8);
      @(posedge clk); #1;
      line = ln; hofs = ho; vofs = vo; sbb = sb; cbb = cb; bpp8 = b8;
      start_v[sel] = 1'b1;
      @(posedge clk); #1;
      start_v = 2'b00;
      line = 8'hA5; hofs = 8'h3C; vofs = 8'h77; sbb = 5'h1F; cbb = 2'h3; bpp8 = ~b8;
   endtask

   task automatic waitDone(input int budget);
      int n = 0;
      while (!s_done && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("done_seen", {31'd0, s_done}, 32'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic loadPlain();
      clearMem();
      mem[0]    = 32'h0000_F002;
      mem[4112] = 32'h7654_3210;
   endtask

   initial begin
      int n;
      int bad;
      logic [7:0] hold_idx;
      logic       hold_tr;

      rst = 1'b1; start_v = 2'b00; line = '0; hofs = '0; vofs = '0; sbb = '0; cbb = '0;
      bpp8 = 1'b0; pix_ready = 1'b1; sel = 0;
      clearMem();
      repeat (3) @(posedge clk);
      #1;
      for (int l = 0; l < 2; l++) begin
         sel = l;
         #0;
         checkOutput("rst_valid", {31'd0, s_valid}, 32'd0);
         checkOutput("rst_busy",  {31'd0, s_busy},  32'd0);
         checkOutput("rst_done",  {31'd0, s_done},  32'd0);
         checkOutput("rst_rd",    {31'd0, s_rd},    32'd0);
         checkOutput("rst_addr",  {18'd0, s_addr},  32'd0);
         checkOutput("rst_pix",   {15'd0, s_transp, s_index, s_x}, 32'd0);
      end
      rst = 1'b0;

      for (int l = 0; l < 2; l++) begin
         sel = l;
         $display("[TB] scenarios with RD_LAT=%0d", l);

         // Plain 4bpp fetch
         loadPlain();
         clearLog();
         applyStimulus(8'd0, 8'd0, 8'd0, 5'd0, 2'd1, 1'b0);
         waitDone(2000);
         checkOutput("s1_rd0",    {18'd0, rd_log[0]}, 32'd0);
         checkOutput("s1_rd1",    {18'd0, rd_log[1]}, 32'd4112);
         checkOutput("s1_x0_tr",  {31'd0, pix_tr_log[0]}, 32'd1);
         checkOutput("s1_x1",     {24'd0, pix_idx_log[1]}, 32'hF1);
         checkOutput("s1_x1_tr",  {31'd0, pix_tr_log[1]}, 32'd0);
         checkOutput("s1_x7",     {24'd0, pix_idx_log[7]}, 32'hF7);
         checkOutput("s1_count",  pix_cnt, 32'd240);
         checkOutput("s1_done",   done_cnt, 32'd1);
         checkOutput("s1_xorder", x_err, 32'd0);
         checkOutput("s1_emitrd", emit_rd_cnt, 32'd0);
         if (sel == 0) checkOutput("s1_busy_cycles", busy_cycles, 32'd300);

         // Horizontal and vertical flip
         clearMem();
         mem[0]    = 32'h0000_0C02;
         mem[4119] = 32'h8765_4321;
         clearLog();
         applyStimulus(8'd0, 8'd0, 8'd0, 5'd0, 2'd1, 1'b0);
         waitDone(2000);
         checkOutput("s2_rd1", {18'd0, rd_log[1]}, 32'd4119);
         checkOutput("s2_x0",  {24'd0, pix_idx_log[0]}, 32'h08);
         checkOutput("s2_x1",  {24'd0, pix_idx_log[1]}, 32'h07);
         checkOutput("s2_x7",  {24'd0, pix_idx_log[7]}, 32'h01);

         // 8bpp with fine scroll
         clearMem();
         mem[0]  = 32'h0003_0001;
         mem[16] = 32'h0706_0504;
         mem[17] = 32'h0B0A_0908;
         mem[48] = 32'h4433_2211;
         mem[49] = 32'h8877_6655;
         clearLog();
         applyStimulus(8'd0, 8'd5, 8'd0, 5'd0, 2'd0, 1'b1);
         waitDone(3000);
         checkOutput("s3_rd1", {18'd0, rd_log[1]}, 32'd16);
         checkOutput("s3_rd2", {18'd0, rd_log[2]}, 32'd17);
         checkOutput("s3_rd4", {18'd0, rd_log[4]}, 32'd48);
         checkOutput("s3_x0",  {24'd0, pix_idx_log[0]}, 32'h09);
         checkOutput("s3_x1",  {24'd0, pix_idx_log[1]}, 32'h0A);
         checkOutput("s3_x2",  {24'd0, pix_idx_log[2]}, 32'h0B);
         checkOutput("s3_x3",  {24'd0, pix_idx_log[3]}, 32'h11);
         checkOutput("s3_count", pix_cnt, 32'd240);
         checkOutput("s3_done",  done_cnt, 32'd1);

         // Backpressure at x=3
         loadPlain();
         pix_ready = 1'b0;
         clearLog();
         applyStimulus(8'd0, 8'd0, 8'd0, 5'd0, 2'd1, 1'b0);
         n = 0;
         while (!s_valid && n < 200) begin
            @(negedge clk);
            n++;
         end
         checkOutput("s4_reach", {31'd0, s_valid}, 32'd1);
         @(posedge clk); #1 pix_ready = 1'b1;
         repeat (3) @(posedge clk);
         #1 pix_ready = 1'b0;
         @(negedge clk);
         checkOutput("s4_stall_x", {24'd0, s_x}, 32'd3);
         hold_idx = s_index;
         hold_tr  = s_transp;
         bad = 0;
         repeat (10) begin
            @(negedge clk);
            if (s_x !== 8'd3 || s_index !== hold_idx || s_transp !== hold_tr ||
                s_valid !== 1'b1 || s_rd !== 1'b0) bad++;
         end
         checkOutput("s4_hold",     bad, 32'd0);
         checkOutput("s4_hold_idx", {24'd0, hold_idx}, 32'hF3);
         @(posedge clk); #1 pix_ready = 1'b1;
         @(negedge clk);
         @(negedge clk);
         checkOutput("s4_resume_x", {24'd0, s_x}, 32'd4);
         waitDone(2000);
         checkOutput("s4_x4",    {24'd0, pix_idx_log[4]}, 32'hF4);
         checkOutput("s4_count", pix_cnt, 32'd240);

         // Horizontal wrap across the map edge
         clearMem();
         clearLog();
         applyStimulus(8'd0, 8'd248, 8'd8, 5'd2, 2'd0, 1'b0);
         waitDone(2000);
         checkOutput("s5_map0",   {18'd0, rd_log[0]}, 32'd1055);
         checkOutput("s5_row0",   {18'd0, rd_log[1]}, 32'd0);
         checkOutput("s5_map1",   {18'd0, rd_log[2]}, 32'd1040);
         checkOutput("s5_count",  pix_cnt, 32'd240);
         checkOutput("s5_done",   done_cnt, 32'd1);
         checkOutput("s5_xorder", x_err, 32'd0);

         // Start while busy, start on the done cycle
         loadPlain();
         clearLog();
         applyStimulus(8'd0, 8'd0, 8'd0, 5'd0, 2'd1, 1'b0);
         @(posedge clk); #1;
         line = 8'd8; vofs = 8'd0; hofs = 8'd0; sbb = 5'd0; cbb = 2'd1; bpp8 = 1'b0;
         start_v[sel] = 1'b1;
         @(posedge clk); #1 start_v = 2'b00;
         n = 0;
         while (!s_done && n < 2000) begin
            @(negedge clk);
            n++;
         end
         checkOutput("s6_done_seen", {31'd0, s_done}, 32'd1);
         start_v[sel] = 1'b1;
         @(posedge clk); #1 start_v = 2'b00;
         @(negedge clk);
         checkOutput("s6_done_start_ign", {31'd0, s_busy}, 32'd0);
         @(negedge clk);
         checkOutput("s6_x1",    {24'd0, pix_idx_log[1]}, 32'hF1);
         checkOutput("s6_count", pix_cnt, 32'd240);
         checkOutput("s6_done",  done_cnt, 32'd1);

         // Asynchronous reset mid-line, then a fresh line
         clearLog();
         applyStimulus(8'd0, 8'd0, 8'd0, 5'd0, 2'd1, 1'b0);
         n = 0;
         while (!(s_valid && s_x == 8'd20) && n < 1000) begin
            @(negedge clk);
            n++;
         end
         checkOutput("s6_reach20", {31'd0, s_valid}, 32'd1);
         #2 rst = 1'b1;
         #1;
         checkOutput("s6_rst_valid", {31'd0, s_valid}, 32'd0);
         checkOutput("s6_rst_busy",  {31'd0, s_busy},  32'd0);
         checkOutput("s6_rst_rd",    {31'd0, s_rd},    32'd0);
         @(posedge clk); #1 rst = 1'b0;
         repeat (3) @(negedge clk);
         checkOutput("s6_rst_nodone", done_cnt, 32'd0);
         clearLog();
         applyStimulus(8'd0, 8'd0, 8'd0, 5'd0, 2'd1, 1'b0);
         waitDone(2000);
         checkOutput("s6_after_x7",    {24'd0, pix_idx_log[7]}, 32'hF7);
         checkOutput("s6_after_count", pix_cnt, 32'd240);
         checkOutput("s6_after_done",  done_cnt, 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
